// File: rtl/rom_port_arbiter_if.sv
// ============================================================================
// Module   : rom_port_arbiter_if
// Brief    : Fetch/LSU request-response bundle plus ROM read port signals.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rom_port_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        if_err_o;

    logic        ls_req_i;
    logic [31:0] ls_addr_i;
    logic        ls_gnt_o;
    logic        ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        ls_err_o;

    logic        flush_i;
    logic        rom_en_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;

    modport slave (
        input  if_req_i, if_addr_i, ls_req_i, ls_addr_i, flush_i, rom_data_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        output rom_en_o, rom_addr_o
    );

    modport master (
        output if_req_i, if_addr_i, ls_req_i, ls_addr_i, flush_i, rom_data_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        input  rom_en_o, rom_addr_o
    );
endinterface

`default_nettype wire

// File: rtl/rom_port_arbiter.sv
// ============================================================================
// Module   : rom_port_arbiter
// Brief    : Shares one ROM read port between fetch (IF) and LSU (LS), LS
//            priority with bounded IF starvation, 1-cycle registered response.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rom_port_arbiter #(
    parameter int DEPTH    = 4096,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    rom_port_arbiter_if.slave  bus
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] starve_cnt;
    logic              force_if;
    logic              if_gnt;
    logic              ls_gnt;
    logic              if_bad;
    logic              ls_bad;
    logic [31:0]       rom_addr;

    logic              if_rvalid;
    logic              if_err;
    logic [31:0]       if_rdata;
    logic              ls_rvalid;
    logic              ls_err;
    logic [31:0]       ls_rdata;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
    endfunction

    // IF overrides LS only once it has been denied MAX_WAIT counted cycles.
    always_comb begin
        force_if = bus.if_req_i && !bus.flush_i && (starve_cnt == MAX_WAIT_CNT);
        ls_gnt   = bus.ls_req_i && !force_if;
        if_gnt   = bus.if_req_i && !bus.flush_i && !ls_gnt;
        if (if_gnt) begin
            rom_addr = bus.if_addr_i;
        end else if (ls_gnt) begin
            rom_addr = bus.ls_addr_i;
        end else begin
            rom_addr = 32'h0;
        end
        if_bad = addr_bad(bus.if_addr_i);
        ls_bad = addr_bad(bus.ls_addr_i);
    end

    // Flush cycles neither advance nor clear the starvation count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.if_req_i || if_gnt) begin
            starve_cnt <= '0;
        end else if (!bus.flush_i && (starve_cnt != MAX_WAIT_CNT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= 32'h0;
        end else begin
            if_rvalid <= if_gnt;
            if_err    <= if_gnt && if_bad;
            if (if_gnt) begin
                if_rdata <= if_bad ? 32'h0 : bus.rom_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ls_rvalid <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= 32'h0;
        end else begin
            ls_rvalid <= ls_gnt;
            ls_err    <= ls_gnt && ls_bad;
            if (ls_gnt) begin
                ls_rdata <= ls_bad ? 32'h0 : bus.rom_data_i;
            end
        end
    end

    assign bus.if_gnt_o    = if_gnt;
    assign bus.ls_gnt_o    = ls_gnt;
    assign bus.rom_en_o    = if_gnt | ls_gnt;
    assign bus.rom_addr_o  = rom_addr;
    assign bus.if_rvalid_o = if_rvalid;
    assign bus.if_err_o    = if_err;
    assign bus.if_rdata_o  = if_rdata;
    assign bus.ls_rvalid_o = ls_rvalid;
    assign bus.ls_err_o    = ls_err;
    assign bus.ls_rdata_o  = ls_rdata;

endmodule

`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
// ============================================================================
// Module   : tb_rom_port_arbiter
// Brief    : Directed and randomized checks of rom_port_arbiter against a
//            behavioural arbitration/response model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rom_port_arbiter;

    localparam int DEPTH    = 4096;
    localparam int MAX_WAIT = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    rom_port_arbiter_if bus ();

    rom_port_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] romw(input logic [31:0] a);
        return {a[17:2] ^ 16'h5A3C, ~a[17:2]};
    endfunction

    function automatic logic is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    assign bus.rom_data_i = romw(bus.rom_addr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: expected registered outputs and IF denial bookkeeping.
    int          denied;
    int          if_wait;
    logic        m_if_rv, m_if_err, m_ls_rv, m_ls_err;
    logic [31:0] m_if_rdata, m_ls_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        denied     = 0;
        if_wait    = 0;
        m_if_rv    = 1'b0;
        m_if_err   = 1'b0;
        m_if_rdata = 32'h0;
        m_ls_rv    = 1'b0;
        m_ls_err   = 1'b0;
        m_ls_rdata = 32'h0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid_o), 0);
        chk({tag, "_if_err"},    32'(bus.if_err_o),    0);
        chk({tag, "_if_rdata"},  bus.if_rdata_o,       0);
        chk({tag, "_ls_rvalid"}, 32'(bus.ls_rvalid_o), 0);
        chk({tag, "_ls_err"},    32'(bus.ls_err_o),    0);
        chk({tag, "_ls_rdata"},  bus.ls_rdata_o,       0);
        chk({tag, "_rom_en"},    32'(bus.rom_en_o),    0);
    endtask

    // One cycle: drive inputs, check grants, then check the registered response.
    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic lr, input logic [31:0] la,
                        input logic fl, output logic g_if, output logic g_ls);
        logic [31:0] e_addr;
        @(negedge clk);
        bus.if_req_i  = ir;
        bus.if_addr_i = ia;
        bus.ls_req_i  = lr;
        bus.ls_addr_i = la;
        bus.flush_i   = fl;
        #1;
        g_ls   = lr && !(ir && !fl && denied >= MAX_WAIT);
        g_if   = ir && !fl && !g_ls;
        e_addr = g_if ? ia : (g_ls ? la : 32'h0);
        chk("if_gnt",   32'(bus.if_gnt_o), 32'(g_if));
        chk("ls_gnt",   32'(bus.ls_gnt_o), 32'(g_ls));
        chk("dual_gnt", 32'(bus.if_gnt_o & bus.ls_gnt_o), 0);
        chk("rom_en",   32'(bus.rom_en_o), 32'(g_if | g_ls));
        chk("rom_addr", bus.rom_addr_o, e_addr);

        m_if_rv  = g_if;
        m_if_err = g_if && is_bad(ia);
        if (g_if) m_if_rdata = is_bad(ia) ? 32'h0 : romw(ia);
        m_ls_rv  = g_ls;
        m_ls_err = g_ls && is_bad(la);
        if (g_ls) m_ls_rdata = is_bad(la) ? 32'h0 : romw(la);

        if (g_if) begin
            chk("if_wait_bound", 32'(if_wait <= MAX_WAIT), 1);
            if_wait = 0;
        end else if (ir && !fl) begin
            if_wait++;
        end else if (!ir) begin
            if_wait = 0;
        end
        if (!ir || g_if) denied = 0;
        else if (!fl)   denied++;

        @(posedge clk);
        #1;
        chk("if_rvalid", 32'(bus.if_rvalid_o), 32'(m_if_rv));
        chk("if_err",    32'(bus.if_err_o),    32'(m_if_err));
        chk("if_rdata",  bus.if_rdata_o,       m_if_rdata);
        chk("ls_rvalid", 32'(bus.ls_rvalid_o), 32'(m_ls_rv));
        chk("ls_err",    32'(bus.ls_err_o),    32'(m_ls_err));
        chk("ls_rdata",  bus.ls_rdata_o,       m_ls_rdata);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        case ($urandom % 8)
            0: a = a | 32'($urandom_range(1, 3));
            1: a = 32'(DEPTH + $urandom_range(0, 1000)) << 2;
            2: a = $urandom;
            default: ;
        endcase
        return a;
    endfunction

    initial begin
        logic        gi, gl;
        logic        ir, lr, fl;
        logic [31:0] ia, la;
        errors = 0;
        checks = 0;
        model_reset();
        rst           = 1'b1;
        bus.if_req_i  = 1'b0;
        bus.if_addr_i = 32'h0;
        bus.ls_req_i  = 1'b0;
        bus.ls_addr_i = 32'h0;
        bus.flush_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // IF only, back-to-back fetches
        step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);
        chk("t1_data0", bus.if_rdata_o, romw(32'h0));
        step(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, gi, gl);
        step(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, gi, gl);
        chk("t1_data2", bus.if_rdata_o, romw(32'h8));
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);

        // Continuous conflict: LS wins four cycles, then IF once
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, gi, gl);
            chk("t2_pattern", 32'(gi), 32'((i % 5) == 4));
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);

        // Error responses
        step(1'b0, 32'h0, 1'b1, 32'h2, 1'b0, gi, gl);
        chk("t3_misalign_err", 32'(bus.ls_err_o), 1);
        step(1'b0, 32'h0, 1'b1, 32'(DEPTH * 4), 1'b0, gi, gl);
        chk("t3_range_err", 32'(bus.ls_err_o), 1);
        step(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, gi, gl);
        chk("t3_ok_data", bus.if_rdata_o, romw(32'h10));

        // Flush with LS idle, then flush during conflict (count must hold)
        step(1'b1, 32'h14, 1'b0, 32'h0, 1'b1, gi, gl);
        step(1'b1, 32'h14, 1'b0, 32'h0, 1'b1, gi, gl);
        step(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, gi, gl);
        chk("t4_resume", 32'(gi), 1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);
        step(1'b1, 32'h18, 1'b1, 32'h1C, 1'b0, gi, gl);
        step(1'b1, 32'h18, 1'b1, 32'h1C, 1'b0, gi, gl);
        step(1'b1, 32'h18, 1'b1, 32'h1C, 1'b1, gi, gl);
        step(1'b1, 32'h18, 1'b1, 32'h1C, 1'b1, gi, gl);
        step(1'b1, 32'h18, 1'b1, 32'h1C, 1'b0, gi, gl);
        step(1'b1, 32'h18, 1'b1, 32'h1C, 1'b0, gi, gl);
        chk("t4_held_count_ls", 32'(gl), 1);
        step(1'b1, 32'h18, 1'b1, 32'h1C, 1'b0, gi, gl);
        chk("t4_held_count_if", 32'(gi), 1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);

        // Reset while a response is outstanding
        step(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, gi, gl);
        @(negedge clk);
        bus.if_req_i = 1'b0;
        rst          = 1'b1;
        #1;
        check_outputs_zero("t5_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);

        // Random traffic; requesters hold req/addr until granted
        ir = 1'b0; lr = 1'b0; ia = 32'h0; la = 32'h0;
        gi = 1'b1; gl = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if (!ir || gi) begin
                ir = ($urandom % 4) != 0;
                ia = rand_addr();
            end
            if (!lr || gl) begin
                lr = ($urandom % 3) != 0;
                la = rand_addr();
            end
            fl = ($urandom % 16) == 0;
            step(ir, ia, lr, la, fl, gi, gl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
